// File: rtl/fp6_result_drain.sv
// fp6_result_drain: packs FP6 systolic-array result beats into register-file
// rows. Each FP6 lane becomes one zero-extended byte. Bytes accumulate into
// the current row, and a full or final row is flushed as one masked row write.
// Lanes that overflow the row wait in a small carry buffer. They become the
// head of the next row.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; no buffered data
// FILL  | accepting array beats into the row buffer
// FLUSH | presenting the row write; carry bytes move down on handshake
module fp6_result_drain #(
  parameter int NUM_LANES = 3,
  parameter int ELEM_W    = 6,
  parameter int BYTE_W    = 8,
  parameter int ROW_BYTES = 64,
  parameter int NUM_ROWS  = 16,
  parameter int NUM_REGS  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(NUM_REGS)-1:0]       dst_reg,
  input  logic [$clog2(NUM_ROWS)-1:0]       dst_row,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LANES*ELEM_W-1:0]       in_data,
  input  logic                              in_last,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [$clog2(NUM_REGS)-1:0]       wr_reg,
  output logic [$clog2(NUM_ROWS)-1:0]       wr_row,
  output logic [ROW_BYTES*BYTE_W-1:0]       wr_data,
  output logic [ROW_BYTES-1:0]              wr_be,
  output logic                              busy,
  output logic                              done
);

  localparam int REG_W       = $clog2(NUM_REGS);
  localparam int ROW_W       = $clog2(NUM_ROWS);
  localparam int PTR_W       = $clog2(ROW_BYTES + 1);
  localparam int CARRY_BYTES = (NUM_LANES > 1) ? NUM_LANES - 1 : 1;
  localparam int EXT_BYTES   = ROW_BYTES + CARRY_BYTES;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                      state, state_n;
  logic [PTR_W-1:0]            ptr, carry_cnt;
  logic [CARRY_BYTES*BYTE_W-1:0] carry_data;
  logic [CARRY_BYTES-1:0]      carry_be;
  logic                        last_pend;

  logic [EXT_BYTES*BYTE_W-1:0] beat_ext, placed_data;
  logic [EXT_BYTES-1:0]        placed_be;
  logic [PTR_W-1:0]            fill_ptr, fill_carry;
  logic                        row_full;
  int                          fill_sum;

  assign in_ready = (state == FILL);
  assign wr_valid = (state == FLUSH);
  assign busy     = (state != IDLE);

  // Place the incoming beat at the current byte pointer. Bytes past the row end land in the carry region.
  always_comb begin
    beat_ext = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      beat_ext[i*BYTE_W +: BYTE_W] = BYTE_W'(in_data[i*ELEM_W +: ELEM_W]);
    end
    placed_data = beat_ext << (int'(ptr) * BYTE_W);
    placed_be   = EXT_BYTES'({NUM_LANES{1'b1}}) << ptr;
    fill_sum    = int'(ptr) + NUM_LANES;
    row_full    = (fill_sum >= ROW_BYTES);
    fill_ptr    = row_full ? PTR_W'(ROW_BYTES) : PTR_W'(fill_sum);
    fill_carry  = row_full ? PTR_W'(fill_sum - ROW_BYTES) : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = FILL;
      FILL:  if (in_valid && (row_full || in_last)) state_n = FLUSH;
      FLUSH: if (wr_ready) begin
               if (!last_pend)           state_n = FILL;
               else if (carry_cnt != '0) state_n = FLUSH;
               else                      state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  // Row buffer, carry buffer, destination address and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data    <= '0;
      wr_be      <= '0;
      wr_reg     <= '0;
      wr_row     <= '0;
      ptr        <= '0;
      carry_cnt  <= '0;
      carry_data <= '0;
      carry_be   <= '0;
      last_pend  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wr_reg     <= dst_reg;
          wr_row     <= dst_row;
          wr_data    <= '0;
          wr_be      <= '0;
          ptr        <= '0;
          carry_cnt  <= '0;
          carry_data <= '0;
          carry_be   <= '0;
          last_pend  <= 1'b0;
        end
        FILL: if (in_valid) begin
          // Unwritten row bytes are zero, so OR-merging is safe.
          wr_data    <= wr_data | placed_data[ROW_BYTES*BYTE_W-1:0];
          wr_be      <= wr_be | placed_be[ROW_BYTES-1:0];
          carry_data <= placed_data[EXT_BYTES*BYTE_W-1:ROW_BYTES*BYTE_W];
          carry_be   <= placed_be[EXT_BYTES-1:ROW_BYTES];
          ptr        <= fill_ptr;
          carry_cnt  <= fill_carry;
          last_pend  <= in_last;
        end
        FLUSH: if (wr_ready) begin
          wr_data    <= (ROW_BYTES*BYTE_W)'(carry_data);
          wr_be      <= ROW_BYTES'(carry_be);
          ptr        <= carry_cnt;
          carry_cnt  <= '0;
          carry_data <= '0;
          carry_be   <= '0;
          if (wr_row == ROW_W'(NUM_ROWS - 1)) begin
            wr_row <= '0;
            wr_reg <= (wr_reg == REG_W'(NUM_REGS - 1)) ? '0 : wr_reg + 1'b1;
          end else begin
            wr_row <= wr_row + 1'b1;
          end
          done <= last_pend && (carry_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp6_result_drain.sv
// Randomized bench for fp6_result_drain. The reference model treats a tile as
// one flat byte stream. That stream is cut into ROW_BYTES chunks, and chunks go
// to consecutive (reg,row) slots.
module tb_fp6_result_drain;
  localparam int NUM_LANES = 3;
  localparam int ELEM_W    = 6;
  localparam int BYTE_W    = 8;
  localparam int ROW_BYTES = 64;
  localparam int NUM_ROWS  = 16;
  localparam int NUM_REGS  = 8;
  localparam int IN_W      = NUM_LANES * ELEM_W;
  localparam int DW        = ROW_BYTES * BYTE_W;

  logic                 clk = 1'b0;
  logic                 reset, start, in_valid, in_ready, in_last;
  logic                 wr_valid, wr_ready, busy, done;
  logic [2:0]           dst_reg, wr_reg;
  logic [3:0]           dst_row, wr_row;
  logic [IN_W-1:0]      in_data;
  logic [DW-1:0]        wr_data;
  logic [ROW_BYTES-1:0] wr_be;

  int vectors = 0;
  int errs    = 0;

  fp6_result_drain #(
    .NUM_LANES(NUM_LANES), .ELEM_W(ELEM_W), .BYTE_W(BYTE_W),
    .ROW_BYTES(ROW_BYTES), .NUM_ROWS(NUM_ROWS), .NUM_REGS(NUM_REGS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dst_reg(dst_reg), .dst_row(dst_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_reg(wr_reg), .wr_row(wr_row),
    .wr_data(wr_data), .wr_be(wr_be), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drain one tile and check every write, done and busy against the chunked byte stream.
  task automatic run_tile(input int rg, input int rw, input int nbeats, input int vpct,
                          input int rpct, input int stall0, input int first_word);
    logic [IN_W-1:0]      beats[$];
    logic [7:0]           bytes[$];
    logic [DW-1:0]        e_data[$];
    logic [ROW_BYTES-1:0] e_be[$];
    int                   e_reg[$];
    int                   e_row[$];
    int nrows, bi, wi, acc, stalls, lin;
    bit exp_done, exp_flush, finished;
    for (int b = 0; b < nbeats; b++) begin
      logic [31:0] w;
      w = $urandom;
      if (b == 0 && first_word >= 0) w = first_word;
      beats.push_back(w[IN_W-1:0]);
      for (int i = 0; i < NUM_LANES; i++) bytes.push_back(8'(w[i*ELEM_W +: ELEM_W]));
    end
    nrows = (bytes.size() + ROW_BYTES - 1) / ROW_BYTES;
    for (int k = 0; k < nrows; k++) begin
      logic [DW-1:0]        d;
      logic [ROW_BYTES-1:0] be;
      lin = (rg * NUM_ROWS + rw + k) % (NUM_REGS * NUM_ROWS);
      e_reg.push_back(lin / NUM_ROWS);
      e_row.push_back(lin % NUM_ROWS);
      d = '0; be = '0;
      for (int j = 0; j < ROW_BYTES; j++) begin
        if (k * ROW_BYTES + j < bytes.size()) begin
          d[j*8 +: 8] = bytes[k*ROW_BYTES + j];
          be[j] = 1'b1;
        end
      end
      e_data.push_back(d);
      e_be.push_back(be);
    end

    @(negedge clk);
    start = 1'b1; dst_reg = rg[2:0]; dst_row = rw[3:0];
    in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0;
    #1;
    chk("idle_before_start", busy, 0);
    bi = 0; wi = 0; acc = 0; stalls = 0;
    exp_done = 0; exp_flush = 0; finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start    = !exp_done && ($urandom_range(15) == 0);
      dst_reg  = 3'($urandom);
      dst_row  = 4'($urandom);
      in_valid = (bi < nbeats) && ($urandom_range(99) < vpct);
      in_data  = (bi < nbeats) ? beats[bi] : IN_W'($urandom);
      in_last  = (bi == nbeats - 1);
      if (wr_valid && wi == 0 && stalls < stall0) begin
        wr_ready = 1'b0;
        stalls++;
      end else begin
        wr_ready = ($urandom_range(99) < rpct);
      end
      #1;
      chk("done", done, exp_done);
      if (exp_done) begin
        finished = 1;
        chk("busy_after_done", busy, 0);
      end else begin
        chk("busy", busy, 1);
        if (exp_flush) chk("flush_latency", wr_valid, 1);
        exp_flush = 0;
        if (wr_valid) begin
          if (wi < nrows) begin
            chk("wr_reg", wr_reg, e_reg[wi]);
            chk("wr_row", wr_row, e_row[wi]);
            chk("wr_data", wr_data, e_data[wi]);
            chk("wr_be", wr_be, e_be[wi]);
          end else begin
            chk("extra_write", wr_valid, 0);
          end
          chk("in_ready_in_flush", in_ready, 0);
          if (wr_ready) begin
            wi++;
            exp_done = (wi == nrows);
          end
        end
        if (in_valid && in_ready) begin
          acc += NUM_LANES;
          exp_flush = in_last || (acc >= (wi + 1) * ROW_BYTES);
          bi++;
        end
      end
    end
    if (!finished) chk("tile_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    #1;
    chk("idle_after_tile", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  // Reset after 10 accepted beats must drop everything without a write.
  task automatic reset_mid_fill();
    @(negedge clk);
    start = 1'b1; dst_reg = 3'd1; dst_row = 4'd3; in_valid = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = IN_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_be", wr_be, 0);
    chk("rst_wr_data", wr_data, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_no_write", wr_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dst_reg = '0; dst_row = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_wr_valid", wr_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_wr_be", wr_be, 0);
    chk("reset_wr_reg", wr_reg, 0);
    chk("reset_wr_row", wr_row, 0);
    reset = 1'b0;

    run_tile(2, 5, 22, 100, 100, 0, -1);
    run_tile(7, 15, 43, 100, 100, 0, -1);
    run_tile(0, 0, 4, 100, 100, 0, 32'h2007F);
    run_tile(3, 2, 30, 100, 100, 5, -1);
    run_tile(4, 4, 1, 100, 100, 0, -1);
    reset_mid_fill();
    run_tile(1, 3, 25, 100, 100, 0, -1);

    repeat (12) begin
      run_tile($urandom_range(NUM_REGS - 1), $urandom_range(NUM_ROWS - 1),
               $urandom_range(60, 1), $urandom_range(100, 40),
               $urandom_range(100, 30), $urandom_range(5), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
